// File: rtl/fpmul_arbiter.sv
// rtl/fpmul_arbiter.sv - round-robin arbiter sharing one IEEE-754 multiplier among four requesters
// Grants one operand pair at a time, drives the multiplier handshakes and returns the product or a timeout NaN.
module fpmul_arbiter #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] req_a,
   input  logic [127:0] req_b,
   input  logic [3:0]   req_stb,
   output logic [3:0]   req_ack,
   output logic [31:0]  resp_z,
   output logic         resp_err,
   output logic [3:0]   resp_stb,
   input  logic [3:0]   resp_ack,
   output logic [31:0]  mul_a,
   output logic [31:0]  mul_b,
   output logic         mul_a_stb,
   output logic         mul_b_stb,
   input  logic         mul_a_ack,
   input  logic         mul_b_ack,
   input  logic [31:0]  mul_z,
   input  logic         mul_z_stb,
   output logic         mul_z_ack,
   output logic         busy,
   output logic [1:0]   grant_id,
   output logic         fault
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ISSUE   = 3'd1;
   localparam logic [2:0] S_WAIT_Z  = 3'd2;
   localparam logic [2:0] S_RESPOND = 3'd3;
   localparam logic [2:0] S_HALT    = 3'd4;

   logic [2:0]  state;
   logic [1:0]  ptr;
   logic [15:0] count;
   logic [1:0]  pick;
   logic [1:0]  idx;
   logic        found;
   logic        grant_en;
   logic        timed_out;
   logic        a_done;
   logic        b_done;

   // First requesting slot at or after the round-robin pointer.
   always_comb begin
      found = 1'b0;
      pick  = ptr;
      idx   = ptr;
      for (int k = 0; k < 4; k++) begin
         idx = ptr + 2'(k);
         if (!found && req_stb[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   always_comb begin
      grant_en  = (state == S_IDLE) && !fault && found && !rst;
      req_ack   = grant_en ? (4'b0001 << pick) : 4'b0000;
      mul_z_ack = (state == S_WAIT_Z);
      resp_stb  = (state == S_RESPOND) ? (4'b0001 << grant_id) : 4'b0000;
      busy      = (state != S_IDLE);
      timed_out = (count == 16'(TIMEOUT_CYCLES));
      a_done    = !mul_a_stb || mul_a_ack;
      b_done    = !mul_b_stb || mul_b_ack;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         ptr       <= 2'd0;
         grant_id  <= 2'd0;
         count     <= 16'd0;
         fault     <= 1'b0;
         resp_z    <= 32'd0;
         resp_err  <= 1'b0;
         mul_a     <= 32'd0;
         mul_b     <= 32'd0;
         mul_a_stb <= 1'b0;
         mul_b_stb <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (grant_en) begin
                  mul_a     <= req_a[32*pick +: 32];
                  mul_b     <= req_b[32*pick +: 32];
                  grant_id  <= pick;
                  ptr       <= pick + 2'd1;
                  count     <= 16'd0;
                  mul_a_stb <= 1'b1;
                  mul_b_stb <= 1'b1;
                  state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               count <= count + 16'd1;
               if (timed_out) begin
                  mul_a_stb <= 1'b0;
                  mul_b_stb <= 1'b0;
                  resp_z    <= 32'h7FC0_0000;
                  resp_err  <= 1'b1;
                  fault     <= 1'b1;
                  state     <= S_RESPOND;
               end else begin
                  if (mul_a_stb && mul_a_ack) mul_a_stb <= 1'b0;
                  if (mul_b_stb && mul_b_ack) mul_b_stb <= 1'b0;
                  if (a_done && b_done) state <= S_WAIT_Z;
               end
            end
            S_WAIT_Z: begin
               count <= count + 16'd1;
               // A result handshaking on the same edge as the deadline is kept.
               if (mul_z_stb) begin
                  resp_z   <= mul_z;
                  resp_err <= 1'b0;
                  state    <= S_RESPOND;
               end else if (timed_out) begin
                  resp_z   <= 32'h7FC0_0000;
                  resp_err <= 1'b1;
                  fault    <= 1'b1;
                  state    <= S_RESPOND;
               end
            end
            S_RESPOND: begin
               if (resp_ack[grant_id]) state <= resp_err ? S_HALT : S_IDLE;
            end
            S_HALT: state <= S_HALT;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpmul_arbiter.sv
// tb/tb_fpmul_arbiter.sv - scoreboard bench for fpmul_arbiter with a behavioural multiplier
module tb_fpmul_arbiter;

   localparam int TO = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] req_a, req_b;
   logic [3:0]   req_stb, req_ack, resp_stb, resp_ack;
   logic [31:0]  resp_z, mul_a, mul_b, mul_z;
   logic         resp_err, mul_a_stb, mul_b_stb, mul_a_ack, mul_b_ack;
   logic         mul_z_stb, mul_z_ack, busy, fault;
   logic [1:0]   grant_id;

   always #5 clk = ~clk;

   fpmul_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .req_a(req_a), .req_b(req_b), .req_stb(req_stb), .req_ack(req_ack),
      .resp_z(resp_z), .resp_err(resp_err), .resp_stb(resp_stb), .resp_ack(resp_ack),
      .mul_a(mul_a), .mul_b(mul_b), .mul_a_stb(mul_a_stb), .mul_b_stb(mul_b_stb),
      .mul_a_ack(mul_a_ack), .mul_b_ack(mul_b_ack),
      .mul_z(mul_z), .mul_z_stb(mul_z_stb), .mul_z_ack(mul_z_ack),
      .busy(busy), .grant_id(grant_id), .fault(fault)
   );

   typedef struct {
      logic [31:0] z;
      logic        err;
   } exp_t;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t exp_q[4][$];
   int   grant_log[$];
   bit   skew_mode = 1'b0;
   bit   never_z = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, want);
      end
   endtask

   task automatic fail_wait(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timed out waiting for the DUT", name);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Round-to-nearest-even single multiply for normal operands with normal products.
   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      logic [47:0] p;
      logic [24:0] m;
      logic        g, s;
      int          e;
      p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      e = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (p[47]) begin
         m = {1'b0, p[47:24]};
         g = p[23];
         s = |p[22:0];
         e = e + 1;
      end else begin
         m = {1'b0, p[46:23]};
         g = p[22];
         s = |p[21:0];
      end
      if (g && (s || m[0])) m = m + 25'd1;
      if (m[24]) begin
         m = m >> 1;
         e = e + 1;
      end
      return {a[31] ^ b[31], e[7:0], m[22:0]};
   endfunction

   function automatic logic [31:0] rand_fp();
      return {1'($urandom), 8'($urandom_range(154, 100)), 23'($urandom)};
   endfunction

   task automatic check_zero(input string t);
      check({t, "_req_ack"}, 32'(req_ack), 32'd0);
      check({t, "_resp_z"}, resp_z, 32'd0);
      check({t, "_resp_err"}, 32'(resp_err), 32'd0);
      check({t, "_resp_stb"}, 32'(resp_stb), 32'd0);
      check({t, "_mul_a"}, mul_a, 32'd0);
      check({t, "_mul_b"}, mul_b, 32'd0);
      check({t, "_mul_stb"}, 32'({mul_a_stb, mul_b_stb}), 32'd0);
      check({t, "_mul_z_ack"}, 32'(mul_z_ack), 32'd0);
      check({t, "_busy"}, 32'(busy), 32'd0);
      check({t, "_grant_id"}, 32'(grant_id), 32'd0);
      check({t, "_fault"}, 32'(fault), 32'd0);
   endtask

   // Grants must follow the rotating scan; responses are matched to each requester's own queue.
   task automatic monitor();
      int   rr;
      int   g;
      int   id;
      logic [3:0] want_ack;
      exp_t e;
      rr = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            rr = 0;
            continue;
         end
         if (req_ack != 4'd0) begin
            g = -1;
            for (int k = 0; k < 4; k++)
               if (g < 0 && req_stb[(rr + k) % 4]) g = (rr + k) % 4;
            want_ack = 4'd0;
            if (g >= 0) want_ack = 4'b0001 << g;
            check("grant", 32'(req_ack), 32'(want_ack));
            if (g >= 0) begin
               rr = (g + 1) % 4;
               grant_log.push_back(g);
            end
         end
         if ((resp_stb & resp_ack) != 4'd0) begin
            id = 0;
            for (int k = 0; k < 4; k++) if (resp_stb[k] && resp_ack[k]) id = k;
            check("resp_onehot", 32'($countones(resp_stb)), 32'd1);
            if (exp_q[id].size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL resp_unexpected: requester %0d got a response with none outstanding", id);
            end else begin
               e = exp_q[id].pop_front();
               check("resp_z", resp_z, e.z);
               check("resp_err", 32'(resp_err), 32'(e.err));
            end
         end
      end
   endtask

   task automatic mul_model();
      logic [31:0] a, b;
      int          da, db, cyc;
      bit          ad, bd, x;
      mul_a_ack = 1'b0;
      mul_b_ack = 1'b0;
      mul_z_stb = 1'b0;
      mul_z     = 32'd0;
      forever begin
         tick();
         if (rst || !(mul_a_stb && mul_b_stb)) continue;
         a = mul_a;
         b = mul_b;
         if (skew_mode) begin
            da = 0;
            db = 5;
         end else begin
            da = int'($urandom_range(2, 0));
            db = int'($urandom_range(2, 0));
         end
         ad = 1'b0;
         bd = 1'b0;
         cyc = 0;
         while (!(ad && bd) && cyc < 40 && !rst) begin
            mul_a_ack = !ad && cyc >= da;
            mul_b_ack = !bd && cyc >= db;
            tick();
            if (mul_a_ack) ad = 1'b1;
            if (mul_b_ack) bd = 1'b1;
            cyc++;
            mul_a_ack = 1'b0;
            mul_b_ack = 1'b0;
            if (!rst && !(ad && bd)) begin
               check("mul_a_stable", mul_a, a);
               check("mul_b_stable", mul_b, b);
               check("mul_a_stb", 32'(mul_a_stb), 32'(!ad));
               check("mul_b_stb", 32'(mul_b_stb), 32'(!bd));
            end
         end
         if (never_z || rst) continue;
         repeat ($urandom_range(2, 0)) tick();
         mul_z     = fmul(a, b);
         mul_z_stb = 1'b1;
         cyc = 0;
         do begin
            @(negedge clk);
            x = mul_z_ack;
            tick();
            cyc++;
         end while (!x && cyc < 40);
         mul_z_stb = 1'b0;
         mul_z     = $urandom;
         if (!x) fail_wait("mul_z_ack");
      end
   endtask

   task automatic requester(input int i, input logic [31:0] a, input logic [31:0] b,
                            input int idle, input int bp, input bit terr);
      exp_t        e;
      int          t;
      logic [31:0] z0;
      repeat (idle) tick();
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
      e.z   = terr ? 32'h7FC0_0000 : fmul(a, b);
      e.err = terr;
      exp_q[i].push_back(e);
      req_stb[i] = 1'b1;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!req_ack[i] && t < 300);
      if (!req_ack[i]) begin
         req_stb[i] = 1'b0;
         fail_wait("grant");
         return;
      end
      tick();
      req_stb[i] = 1'b0;
      req_a[32*i +: 32] = $urandom;
      req_b[32*i +: 32] = $urandom;
      check("issue_stb", 32'({mul_a_stb, mul_b_stb}), 32'd3);
      check("issue_grant_id", 32'(grant_id), 32'(i));
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!resp_stb[i] && t < 400);
      if (!resp_stb[i]) begin
         fail_wait("resp_stb");
         return;
      end
      z0 = resp_z;
      for (int k = 0; k < bp; k++) begin
         @(negedge clk);
         check("bp_resp_stb", 32'(resp_stb), 32'(4'b0001 << i));
         check("bp_resp_z", resp_z, z0);
         check("bp_req_ack", 32'(req_ack), 32'd0);
         check("bp_busy", 32'(busy), 32'd1);
      end
      tick();
      resp_ack[i] = 1'b1;
      tick();
      resp_ack[i] = 1'b0;
   endtask

   task automatic rloop(input int i);
      repeat (10)
         requester(i, rand_fp(), rand_fp(), int'($urandom_range(5, 0)), int'($urandom_range(3, 0)), 1'b0);
   endtask

   initial begin
      int  t;
      bit  any;
      rst      = 1'b1;
      req_a    = '0;
      req_b    = '0;
      req_stb  = 4'b1111;
      resp_ack = 4'b0000;
      fork
         monitor();
         mul_model();
      join_none
      repeat (3) tick();
      check_zero("reset");
      req_stb = 4'b0000;
      rst = 1'b0;
      repeat (2) tick();

      grant_log.delete();
      requester(0, 32'h3FDE_B852, 32'hC10C_1893, 0, 0, 1'b0);
      check("single_grant_count", 32'(grant_log.size()), 32'd1);

      // Abandon a transaction while the arbiter waits for the product.
      never_z = 1'b1;
      req_a[63:32] = rand_fp();
      req_b[63:32] = rand_fp();
      req_stb[1] = 1'b1;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!req_ack[1] && t < 50);
      if (!req_ack[1]) fail_wait("mid_grant");
      tick();
      req_stb[1] = 1'b0;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!mul_z_ack && t < 50);
      if (!mul_z_ack) fail_wait("mid_wait_z");
      #2;
      rst = 1'b1;
      #1;
      check_zero("rst_mid");
      repeat (2) tick();
      rst = 1'b0;
      never_z = 1'b0;
      tick();

      grant_log.delete();
      fork
         requester(0, 32'h3F80_0000, 32'h4000_0000, 0, 0, 1'b0);
         requester(1, 32'h3F80_0000, 32'h4000_0001, 0, 0, 1'b0);
         requester(2, 32'h3F80_0000, 32'h4000_0002, 0, 0, 1'b0);
         requester(3, 32'h3F80_0000, 32'h4000_0003, 0, 0, 1'b0);
      join
      check("contention_count", 32'(grant_log.size()), 32'd4);
      for (int k = 0; k < 4; k++)
         if (k < grant_log.size()) check("contention_order", 32'(grant_log[k]), 32'(k));

      fork
         requester(2, rand_fp(), rand_fp(), 0, 20, 1'b0);
         requester(3, rand_fp(), rand_fp(), 2, 0, 1'b0);
      join

      skew_mode = 1'b1;
      requester(1, rand_fp(), rand_fp(), 0, 0, 1'b0);
      skew_mode = 1'b0;

      fork
         rloop(0);
         rloop(1);
         rloop(2);
         rloop(3);
      join

      never_z = 1'b1;
      requester(0, rand_fp(), rand_fp(), 0, 0, 1'b1);
      tick();
      check("halt_fault", 32'(fault), 32'd1);
      check("halt_busy", 32'(busy), 32'd1);
      req_stb = 4'b1111;
      any = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (req_ack != 4'd0) any = 1'b1;
      end
      check("halt_no_ack", 32'(any), 32'd0);
      req_stb = 4'b0000;

      for (int k = 0; k < 4; k++) check("queue_drained", 32'(exp_q[k].size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
